ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch_pkg.sv | 24 ++
 rtl/ifetch.sv | 169 ++++++++++++++++
 tb/tb_ifetch.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: constants and types shared by the instruction-fetch block.
//   - FSM state encodings
//   - reset PC and legal fetch window (30-bit word addresses)
//   - watchdog limit and the helper that range-checks a PC
package ifetch_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [29:0] RESET_PC   = 30'h0000_0C00;  // byte 0x3000
    localparam logic [29:0] PC_LO      = 30'h0000_0C00;  // byte 0x3000
    localparam logic [29:0] PC_HI      = 30'h0000_13FF;  // byte 0x4FFC
    localparam int          WDOG_LIMIT = 16;
    // Count value seen during the last BUSY cycle before expiry.
    localparam logic [3:0]  WDOG_LAST  = 4'(WDOG_LIMIT - 1);

    // A PC may be fetched only inside the instruction window.
    function automatic logic pc_legal(input logic [29:0] addr);
        return (addr >= PC_LO) && (addr <= PC_HI);
    endfunction

endpackage

// File: rtl/ifetch.sv
// ifetch: instruction-fetch stage. Holds the PC, issues one outstanding
// instruction-memory read at a time, captures the returned word and guards
// the fetch with a range check and a watchdog.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   fetch                 request a fetch at pc
//   pcwr, npc[29:0]       load a new PC (deferred while a fetch is in flight)
//   flush                 abort an outstanding fetch
//   imem_rdata, imem_ack  instruction memory response
//   imem_req, imem_addr   instruction memory request (level, held while busy)
//   pc, instr             current PC and instruction register
//   instr_valid, busy     instr update pulse, fetch outstanding
//   ifault                address error or watchdog expiry pulse
module ifetch
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch,
    input  logic        pcwr,
    input  logic [29:0] npc,
    input  logic        flush,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    output logic [29:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        busy,
    output logic        ifault
);

    state_e      state_q, state_d;
    logic [29:0] pc_q, pc_d;
    logic [29:0] addr_q, addr_d;
    logic [29:0] pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        req_q, req_d;
    logic        busy_q, busy_d;
    logic        ifault_q, ifault_d;
    logic [3:0]  wdog_q, wdog_d;
    logic        exit_s;

    // Next-state, datapath and output computation.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        addr_d        = addr_q;
        pend_d        = pend_q;
        pend_vld_d    = pend_vld_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        req_d         = req_q;
        busy_d        = busy_q;
        ifault_d      = 1'b0;
        wdog_d        = wdog_q;
        exit_s        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_d  = 1'b0;
                busy_d = 1'b0;
                wdog_d = 4'd0;
                // The fetch uses the PC as it stands now, even if pcwr
                // replaces it at this same edge; imem_addr keeps its copy.
                if (fetch && !flush) begin
                    if (pc_legal(pc_q)) begin
                        state_d = ST_BUSY;
                        req_d   = 1'b1;
                        busy_d  = 1'b1;
                        addr_d  = pc_q;
                    end else begin
                        ifault_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
                if (pcwr) begin
                    pc_d = npc;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_BUSY: begin
                exit_s = flush || imem_ack || (wdog_q == WDOG_LAST);
                // Flush beats a same-cycle ack; ack beats watchdog expiry.
                if (flush) begin
                    instr_d = instr_q;
                end else if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                end else if (wdog_q == WDOG_LAST) begin
                    ifault_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 4'd1;
                end

                if (exit_s) begin
                    state_d    = ST_IDLE;
                    req_d      = 1'b0;
                    busy_d     = 1'b0;
                    wdog_d     = 4'd0;
                    pend_vld_d = 1'b0;
                    // A pcwr arriving with the exit is the newest value and
                    // overrides anything deferred earlier.
                    if (pcwr) begin
                        pc_d = npc;
                    end else if (pend_vld_q) begin
                        pc_d = pend_q;
                    end else begin
                        pc_d = pc_q;
                    end
                end else if (pcwr) begin
                    pend_d     = npc;
                    pend_vld_d = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                busy_d  = 1'b0;
                wdog_d  = 4'd0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            addr_q        <= RESET_PC;
            pend_q        <= 30'h0000_0000;
            pend_vld_q    <= 1'b0;
            instr_q       <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            req_q         <= 1'b0;
            busy_q        <= 1'b0;
            ifault_q      <= 1'b0;
            wdog_q        <= 4'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            addr_q        <= addr_d;
            pend_q        <= pend_d;
            pend_vld_q    <= pend_vld_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            req_q         <= req_d;
            busy_q        <= busy_d;
            ifault_q      <= ifault_d;
            wdog_q        <= wdog_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign busy        = busy_q;
    assign ifault      = ifault_q;

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed vector table, hand-written multi-cycle sequences and
// randomized traffic, all checked against a transaction-level reference.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst_n, fetch, pcwr, flush, imem_ack;
    logic [29:0] npc;
    logic [31:0] imem_rdata;
    logic        imem_req, instr_valid, busy, ifault;
    logic [29:0] imem_addr, pc;
    logic [31:0] instr;

    int checks = 0;
    int failures = 0;

    ifetch dut (
        .clk(clk), .rst_n(rst_n), .fetch(fetch), .pcwr(pcwr), .npc(npc),
        .flush(flush), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .instr(instr),
        .instr_valid(instr_valid), .busy(busy), .ifault(ifault)
    );

    always #5 clk = ~clk;

    // Reference: one fetch transaction at a time, counted in cycles.
    bit          m_busy;
    int          m_age;           // BUSY cycles elapsed in the current fetch
    logic [29:0] m_pc, m_addr;
    logic [31:0] m_instr;
    bit          m_valid, m_fault;
    logic [29:0] m_pcwr_hist[$];  // PC writes seen during the current fetch

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        m_valid = 1'b0;
        m_fault = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0; m_age = 0; m_pc = 30'h0C00; m_instr = 32'h0;
            m_pcwr_hist.delete();
        end else if (!m_busy) begin
            if (fetch && !flush) begin
                if (m_pc >= 30'h0C00 && m_pc <= 30'h13FF) begin
                    m_busy = 1'b1; m_age = 0; m_addr = m_pc;
                end else begin
                    m_fault = 1'b1;
                end
            end
            if (pcwr) m_pc = npc;
        end else begin
            m_age = m_age + 1;
            if (pcwr) m_pcwr_hist.push_back(npc);
            if (flush || imem_ack || m_age == 16) begin
                if (!flush && imem_ack) begin
                    m_instr = imem_rdata; m_valid = 1'b1;
                end else if (!flush) begin
                    m_fault = 1'b1;
                end
                if (m_pcwr_hist.size() > 0) m_pc = m_pcwr_hist[$];
                m_pcwr_hist.delete();
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("pc", pc, m_pc);
        check("instr", instr, m_instr);
        check("instr_valid", instr_valid, m_valid);
        check("imem_req", imem_req, m_busy);
        check("busy", busy, m_busy);
        check("ifault", ifault, m_fault);
        if (m_busy) check("imem_addr", imem_addr, m_addr);
    endtask

    task automatic drive(input logic r, input logic f, input logic w, input logic [29:0] n,
                         input logic fl, input logic a, input logic [31:0] d);
        rst_n = r; fetch = f; pcwr = w; npc = n; flush = fl; imem_ack = a; imem_rdata = d;
    endtask

    typedef struct {
        logic        rst, fetch, pcwr, flush, ack;
        logic [29:0] npc;
        logic [31:0] rdata;
        logic        req, valid, fault;
        logic [29:0] pc, addr;
        logic [31:0] instr;
    } vec_t;

    function automatic vec_t mk(logic r, logic f, logic w, logic [29:0] n, logic fl, logic a,
                                logic [31:0] d, logic rq, logic v, logic flt,
                                logic [29:0] p, logic [29:0] ad, logic [31:0] ins);
        vec_t x;
        x.rst = r; x.fetch = f; x.pcwr = w; x.npc = n; x.flush = fl; x.ack = a; x.rdata = d;
        x.req = rq; x.valid = v; x.fault = flt; x.pc = p; x.addr = ad; x.instr = ins;
        return x;
    endfunction

    function automatic logic [29:0] pick_npc();
        case ($urandom_range(0, 5))
            0: return 30'h0BFF;
            1: return 30'h0C00;
            2: return 30'h13FF;
            3: return 30'h1400;
            default: return 30'(30'h0C00 + $urandom_range(0, 30'h7FF));
        endcase
    endfunction

    vec_t vt[19];

    initial begin
        int k;
        logic [31:0] saved;
        drive(1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 32'h0);
        m_busy = 1'b0; m_age = 0; m_pc = 30'h0C00; m_addr = 30'h0C00; m_instr = 32'h0;

        //        rst  fet  pcw  npc       fl   ack  rdata          req  vld  flt  pc        addr      instr
        vt[0]  = mk(1'b0,1'b0,1'b0,30'h0000,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,30'h0C00,30'h0C00,32'h0);
        vt[1]  = mk(1'b0,1'b0,1'b0,30'h0000,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,30'h0C00,30'h0C00,32'h0);
        vt[2]  = mk(1'b1,1'b1,1'b0,30'h0000,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,30'h0C00,30'h0C00,32'h0);
        vt[3]  = mk(1'b1,1'b0,1'b0,30'h0000,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,30'h0C00,30'h0C00,32'h0);
        vt[4]  = mk(1'b1,1'b0,1'b0,30'h0000,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,30'h0C00,30'h0C00,32'h0);
        vt[5]  = mk(1'b1,1'b0,1'b0,30'h0000,1'b0,1'b1,32'h3C011234, 1'b0,1'b1,1'b0,30'h0C00,30'h0C00,32'h3C011234);
        vt[6]  = mk(1'b1,1'b0,1'b0,30'h0000,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,30'h0C00,30'h0C00,32'h3C011234);
        vt[7]  = mk(1'b1,1'b1,1'b0,30'h0000,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,30'h0C00,30'h0C00,32'h3C011234);
        vt[8]  = mk(1'b1,1'b0,1'b1,30'h0C01,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,30'h0C00,30'h0C00,32'h3C011234);
        vt[9]  = mk(1'b1,1'b0,1'b0,30'h0000,1'b0,1'b1,32'h00001111, 1'b0,1'b1,1'b0,30'h0C01,30'h0C00,32'h00001111);
        vt[10] = mk(1'b1,1'b0,1'b0,30'h0000,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,30'h0C01,30'h0C00,32'h00001111);
        vt[11] = mk(1'b1,1'b0,1'b1,30'h0800,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,30'h0800,30'h0C00,32'h00001111);
        vt[12] = mk(1'b1,1'b1,1'b0,30'h0000,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,30'h0800,30'h0C00,32'h00001111);
        vt[13] = mk(1'b1,1'b0,1'b0,30'h0000,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,30'h0800,30'h0C00,32'h00001111);
        vt[14] = mk(1'b1,1'b0,1'b0,30'h0000,1'b0,1'b1,32'hDEADBEEF, 1'b0,1'b0,1'b0,30'h0800,30'h0C00,32'h00001111);
        vt[15] = mk(1'b1,1'b0,1'b1,30'h0C10,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,30'h0C10,30'h0C00,32'h00001111);
        vt[16] = mk(1'b1,1'b1,1'b0,30'h0000,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,30'h0C10,30'h0C10,32'h00001111);
        vt[17] = mk(1'b1,1'b0,1'b1,30'h1060,1'b1,1'b1,32'hAAAA5555, 1'b0,1'b0,1'b0,30'h1060,30'h0C10,32'h00001111);
        vt[18] = mk(1'b1,1'b0,1'b0,30'h0000,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,30'h1060,30'h0C10,32'h00001111);

        for (int i = 0; i < 19; i++) begin
            drive(vt[i].rst, vt[i].fetch, vt[i].pcwr, vt[i].npc, vt[i].flush, vt[i].ack, vt[i].rdata);
            step();
            check($sformatf("vec%0d_req", i), imem_req, vt[i].req);
            check($sformatf("vec%0d_busy", i), busy, vt[i].req);
            check($sformatf("vec%0d_valid", i), instr_valid, vt[i].valid);
            check($sformatf("vec%0d_fault", i), ifault, vt[i].fault);
            check($sformatf("vec%0d_pc", i), pc, vt[i].pc);
            check($sformatf("vec%0d_instr", i), instr, vt[i].instr);
            if (vt[i].req) check($sformatf("vec%0d_addr", i), imem_addr, vt[i].addr);
        end

        // Watchdog: no ack for 16 BUSY cycles, then a late ack is ignored.
        saved = instr;
        drive(1'b1, 1'b1, 1'b0, 30'h0, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 32'h0);
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (ifault === 1'b1) begin
                k = c;
                break;
            end
            check("timeout_req_held", imem_req, 1'b1);
        end
        check("timeout_cycle", k, 16);
        check("timeout_req_drop", imem_req, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 1'b1, 32'h12345678);
        step();
        check("late_ack_instr", instr, saved);
        check("late_ack_valid", instr_valid, 1'b0);

        // Reset in the middle of a fetch, then a stale ack.
        drive(1'b1, 1'b1, 1'b0, 30'h0, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b1, 1'b0, 1'b1, 30'h0D00, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 32'h0);
        step();
        check("rst_pc", pc, 30'h0C00);
        check("rst_instr", instr, 32'h0);
        check("rst_req", imem_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_fault", ifault, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 30'h0, 1'b0, 1'b1, 32'h55AA55AA);
        step();
        check("post_rst_ack_instr", instr, 32'h0);
        check("post_rst_ack_valid", instr_valid, 1'b0);

        // Randomized traffic against the reference.
        for (int c = 0; c < 800; c++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 3) == 0),
                  pick_npc(),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 9) == 0),
                  $urandom());
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
